pcs_sync_multilane: RTL and testbench

Parametrised multi-lane 8B/10B receive code-group synchronization block for the PCS receive path, between the per-lane deserializers and the receive decoders. Each lane runs an independent comma-based acquire/maintain state machine with configurable acquisition depth and error hysteresis. The block forwards the code groups as SUDI with a per-lane `rx_even` phase and publishes per-lane and aggregate sync status.

---
 rtl/pcs_sync_multilane_pkg.sv | 54 +++++
 rtl/pcs_sync_multilane_lane.sv | 160 ++++++++++++++++
 rtl/pcs_sync_multilane.sv | 66 ++++++
 tb/tb_pcs_sync_multilane.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_sync_multilane_pkg.sv
// Shared 8B/10B code-group constants, lane state encoding and code-group classifiers
// for the multi-lane PCS receive synchronizer.
package pcs_sync_multilane_pkg;

  localparam int CG_W = 10;

  typedef enum logic [1:0] {
    ST_LOSS_OF_SYNC  = 2'd0,
    ST_COMMA_DETECT  = 2'd1,
    ST_ACQUIRE_SYNC  = 2'd2,
    ST_SYNC_ACQUIRED = 2'd3
  } sync_state_e;

  // Code groups are abcdei fghj with 'a' in bit 9.
  localparam logic [CG_W-1:0] K28P5_RDN = 10'b0011111010;
  localparam logic [CG_W-1:0] K28P5_RDP = 10'b1100000101;
  localparam logic [CG_W-1:0] D16P2     = 10'b1001000101;

  localparam logic [6:0] COMMA_RDN = K28P5_RDN[9:3];
  localparam logic [6:0] COMMA_RDP = K28P5_RDP[9:3];
  localparam logic [5:0] K28_RDN   = K28P5_RDN[9:4];
  localparam logic [5:0] K28_RDP   = K28P5_RDP[9:4];

  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Comma pattern abcdeif of K28.1/K28.5/K28.7 in either disparity.
  function automatic logic is_comma(input logic [CG_W-1:0] cg);
    return (cg[9:3] == COMMA_RDN) || (cg[9:3] == COMMA_RDP);
  endfunction

  // Structural validity: both sub-blocks must have a legal disparity (6b: 2..4 ones, 4b: 1..3 ones).
  function automatic logic is_valid(input logic [CG_W-1:0] cg);
    logic [2:0] n6;
    logic [2:0] n4;
    n6 = ones6(cg[9:4]);
    n4 = ones6({2'b00, cg[3:0]});
    return (n6 >= 3'd2) && (n6 <= 3'd4) && (n4 >= 3'd1) && (n4 <= 3'd3);
  endfunction

  // Data is any valid group that is neither a comma nor a K28.x special.
  function automatic logic is_data(input logic [CG_W-1:0] cg);
    return is_valid(cg) && !is_comma(cg) && (cg[9:4] != K28_RDN) && (cg[9:4] != K28_RDP);
  endfunction

  function automatic logic cg_bad(input logic [CG_W-1:0] cg, input logic rx_even);
    return !is_valid(cg) || (is_comma(cg) && rx_even);
  endfunction

endpackage

// File: rtl/pcs_sync_multilane_lane.sv
// One lane of code-group synchronization: acquire/maintain FSM, hysteresis counters and
// signal-change lane reset. Optional sync-loss counter under SYNC_LOSS_CNT_EN.
//
// state             | meaning
// ST_LOSS_OF_SYNC   | waiting for any comma with signal present (or loopback)
// ST_COMMA_DETECT   | comma seen, next group must be data
// ST_ACQUIRE_SYNC   | between comma+data pairs, waiting for an even-aligned comma
// ST_SYNC_ACQUIRED  | locked; bad groups climb error levels, runs of good groups descend
module pcs_sync_lane
  import pcs_sync_multilane_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int ACQ_COMMAS = 3,
  parameter int GOOD_CGS   = 4,
  parameter int BAD_LEVELS = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_loopback,
  input  logic             i_signal_detect,
  input  logic [WIDTH-1:0] i_code_group,
  output logic             o_sync,
  output logic             o_rx_even
`ifdef SYNC_LOSS_CNT_EN
  ,
  output logic [7:0]       o_loss_cnt
`endif
);

  localparam int ACQ_W  = $clog2(ACQ_COMMAS + 1);
  localparam int GOOD_W = $clog2(GOOD_CGS + 1);
  localparam int BAD_W  = $clog2(BAD_LEVELS + 1);

  localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(ACQ_COMMAS - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_CGS - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LEVELS - 1);

  sync_state_e        r_state;
  logic [ACQ_W-1:0]   r_acq_cnt;
  logic [GOOD_W-1:0]  r_good_cnt;
  logic [BAD_W-1:0]   r_bad_lvl;
  logic               r_rx_even;
  logic               r_sig_prev;

  sync_state_e        w_state_nx;
  logic [ACQ_W-1:0]   w_acq_nx;
  logic [GOOD_W-1:0]  w_good_nx;
  logic [BAD_W-1:0]   w_bad_nx;
  logic               w_rx_even_nx;
  logic               w_loss_evt;
  logic               w_comma;
  logic               w_data;
  logic               w_bad;
  logic               w_sig_chg;

  assign w_comma   = is_comma(i_code_group);
  assign w_data    = is_data(i_code_group);
  assign w_bad     = cg_bad(i_code_group, r_rx_even);
  assign w_sig_chg = (i_signal_detect ^ r_sig_prev) & ~i_loopback;

  always_comb begin
    w_state_nx = r_state;
    w_acq_nx   = r_acq_cnt;
    w_good_nx  = r_good_cnt;
    w_bad_nx   = r_bad_lvl;
    w_loss_evt = 1'b0;
    case (r_state)
      ST_LOSS_OF_SYNC: begin
        if (w_comma && (i_signal_detect || i_loopback)) begin
          w_state_nx = ST_COMMA_DETECT;
          w_acq_nx   = '0;
        end
      end
      ST_COMMA_DETECT: begin
        if (!w_data) begin
          w_state_nx = ST_LOSS_OF_SYNC;
        end else if (r_acq_cnt == ACQ_LAST) begin
          w_state_nx = ST_SYNC_ACQUIRED;
          w_bad_nx   = '0;
          w_good_nx  = '0;
        end else begin
          w_state_nx = ST_ACQUIRE_SYNC;
          w_acq_nx   = r_acq_cnt + ACQ_W'(1);
        end
      end
      ST_ACQUIRE_SYNC: begin
        if (w_comma && !r_rx_even) w_state_nx = ST_COMMA_DETECT;
        else if (w_bad)            w_state_nx = ST_LOSS_OF_SYNC;
      end
      ST_SYNC_ACQUIRED: begin
        if (w_bad) begin
          w_good_nx = '0;
          if (r_bad_lvl == BAD_LAST) begin
            w_state_nx = ST_LOSS_OF_SYNC;
            w_loss_evt = 1'b1;
          end else begin
            w_bad_nx = r_bad_lvl + BAD_W'(1);
          end
        end else if (r_bad_lvl != '0) begin
          // A full run of good groups retires one error level.
          if (r_good_cnt == GOOD_LAST) begin
            w_bad_nx  = r_bad_lvl - BAD_W'(1);
            w_good_nx = '0;
          end else begin
            w_good_nx = r_good_cnt + GOOD_W'(1);
          end
        end else begin
          w_good_nx = '0;
        end
      end
      default: w_state_nx = ST_LOSS_OF_SYNC;
    endcase
    w_rx_even_nx = (w_state_nx == ST_COMMA_DETECT) ? 1'b1 : ~r_rx_even;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_LOSS_OF_SYNC;
      r_acq_cnt  <= '0;
      r_good_cnt <= '0;
      r_bad_lvl  <= '0;
      r_rx_even  <= 1'b0;
      r_sig_prev <= i_signal_detect;
    end else begin
      r_sig_prev <= i_signal_detect;
      if (w_sig_chg) begin
        r_state    <= ST_LOSS_OF_SYNC;
        r_acq_cnt  <= '0;
        r_good_cnt <= '0;
        r_bad_lvl  <= '0;
        r_rx_even  <= 1'b0;
      end else begin
        r_state    <= w_state_nx;
        r_acq_cnt  <= w_acq_nx;
        r_good_cnt <= w_good_nx;
        r_bad_lvl  <= w_bad_nx;
        r_rx_even  <= w_rx_even_nx;
      end
    end
  end

`ifdef SYNC_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  // A signal-change lane reset pre-empts the loss transition, so it is not counted.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && !w_sig_chg && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign o_loss_cnt = r_loss_cnt;
`endif

  assign o_sync    = (r_state == ST_SYNC_ACQUIRED);
  assign o_rx_even = r_rx_even;

endmodule

// File: rtl/pcs_sync_multilane.sv
// Multi-lane 8B/10B receive synchronizer top: LANES independent lanes, SUDI pipeline and
// aggregate all_sync. Define SYNC_LOSS_CNT_EN to add per-lane sync-loss counters.
module pcs_sync_multilane
  import pcs_sync_multilane_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int WIDTH      = 10,
  parameter int ACQ_COMMAS = 3,
  parameter int GOOD_CGS   = 4,
  parameter int BAD_LEVELS = 4
) (
  input  logic                   clk,
  input  logic                   mr_main_reset,
  input  logic                   mr_loopback,
  input  logic [LANES-1:0]       signal_detect,
  input  logic [LANES*WIDTH-1:0] code_group,
  output logic [LANES-1:0]       code_sync_status,
  output logic [LANES-1:0]       rx_even,
  output logic [LANES*WIDTH-1:0] SUDI,
  output logic                   all_sync
`ifdef SYNC_LOSS_CNT_EN
  ,
  output logic [LANES*8-1:0]     loss_cnt
`endif
);

  logic [LANES-1:0]       w_sync;
  logic [LANES*WIDTH-1:0] r_sudi;
  logic                   r_all_sync;

  for (genvar g = 0; g < LANES; g++) begin : gen_lane
    pcs_sync_lane #(
      .WIDTH      (WIDTH),
      .ACQ_COMMAS (ACQ_COMMAS),
      .GOOD_CGS   (GOOD_CGS),
      .BAD_LEVELS (BAD_LEVELS)
    ) u_lane (
      .clk             (clk),
      .i_rst_n         (mr_main_reset),
      .i_loopback      (mr_loopback),
      .i_signal_detect (signal_detect[g]),
      .i_code_group    (code_group[g*WIDTH +: WIDTH]),
      .o_sync          (w_sync[g]),
      .o_rx_even       (rx_even[g])
`ifdef SYNC_LOSS_CNT_EN
      ,
      .o_loss_cnt      (loss_cnt[g*8 +: 8])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (!mr_main_reset) begin
      r_sudi     <= '0;
      r_all_sync <= 1'b0;
    end else begin
      r_sudi     <= code_group;
      r_all_sync <= &w_sync;
    end
  end

  assign code_sync_status = w_sync;
  assign SUDI             = r_sudi;
  assign all_sync         = r_all_sync;

endmodule

// File: tb/tb_pcs_sync_multilane.sv
// Scoreboard bench for pcs_sync_multilane: two parameter sets driven by the same stimulus,
// each followed by a behavioural lane model; a monitor pops expectations every cycle.
module tb_pcs_sync_multilane;
  import pcs_sync_multilane_pkg::*;

  localparam int L = 4;
  localparam int W = 10;
  localparam int M_LOS = 0, M_CD = 1, M_AS = 2, M_SA = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           lb = 1'b0;
  logic [L-1:0]   sd = '1;
  logic [L*W-1:0] cg = '0;

  logic [L-1:0]   st_a, rx_a, st_b, rx_b;
  logic [L*W-1:0] sudi_a, sudi_b;
  logic           all_a, all_b;
  logic [L*8-1:0] loss_a, loss_b;

  pcs_sync_multilane #(.LANES(L), .WIDTH(W), .ACQ_COMMAS(3), .GOOD_CGS(4), .BAD_LEVELS(4)) dut_a (
    .clk(clk), .mr_main_reset(rst_n), .mr_loopback(lb), .signal_detect(sd), .code_group(cg),
    .code_sync_status(st_a), .rx_even(rx_a), .SUDI(sudi_a), .all_sync(all_a)
`ifdef SYNC_LOSS_CNT_EN
    , .loss_cnt(loss_a)
`endif
  );

  pcs_sync_multilane #(.LANES(L), .WIDTH(W), .ACQ_COMMAS(1), .GOOD_CGS(2), .BAD_LEVELS(2)) dut_b (
    .clk(clk), .mr_main_reset(rst_n), .mr_loopback(lb), .signal_detect(sd), .code_group(cg),
    .code_sync_status(st_b), .rx_even(rx_b), .SUDI(sudi_b), .all_sync(all_b)
`ifdef SYNC_LOSS_CNT_EN
    , .loss_cnt(loss_b)
`endif
  );

`ifndef SYNC_LOSS_CNT_EN
  assign loss_a = '0;
  assign loss_b = '0;
`endif

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model, one set of lane variables per instance.
  int P_ACQ[2]  = '{3, 1};
  int P_GOOD[2] = '{4, 2};
  int P_BAD[2]  = '{4, 2};
  int m_st[2][L], m_acq[2][L], m_bad[2][L], m_good[2][L], m_loss[2][L];
  bit m_rxe[2][L], m_sigp[2][L];
  logic [L*W-1:0] m_sudi[2];
  bit m_all[2];

  function automatic bit f_comma(logic [9:0] g);
    return (g[9:3] == 7'b0011111) || (g[9:3] == 7'b1100000);
  endfunction
  function automatic bit f_valid(logic [9:0] g);
    int a, b;
    a = $countones(g[9:4]);
    b = $countones(g[3:0]);
    return (a >= 2) && (a <= 4) && (b >= 1) && (b <= 3);
  endfunction
  function automatic bit f_data(logic [9:0] g);
    return f_valid(g) && !f_comma(g) && (g[9:4] != 6'b001111) && (g[9:4] != 6'b110000);
  endfunction

  task automatic model_step(input int k, input logic [L*W-1:0] c, input logic [L-1:0] s,
                            input bit l, input bit r);
    if (!r) begin
      for (int i = 0; i < L; i++) begin
        m_st[k][i] = M_LOS; m_acq[k][i] = 0; m_bad[k][i] = 0; m_good[k][i] = 0;
        m_loss[k][i] = 0; m_rxe[k][i] = 0; m_sigp[k][i] = s[i];
      end
      m_sudi[k] = '0;
      m_all[k] = 0;
    end else begin
      bit allnow;
      allnow = 1;
      for (int i = 0; i < L; i++) allnow &= (m_st[k][i] == M_SA);
      m_all[k] = allnow;
      m_sudi[k] = c;
      for (int i = 0; i < L; i++) begin
        logic [9:0] g;
        bit chg, cm, dt, bd;
        int nst;
        g = c[i*W +: W];
        chg = (s[i] != m_sigp[k][i]) && !l;
        m_sigp[k][i] = s[i];
        if (chg) begin
          m_st[k][i] = M_LOS; m_acq[k][i] = 0; m_bad[k][i] = 0; m_good[k][i] = 0; m_rxe[k][i] = 0;
        end else begin
          cm = f_comma(g);
          dt = f_data(g);
          bd = !f_valid(g) || (cm && m_rxe[k][i]);
          nst = m_st[k][i];
          case (m_st[k][i])
            M_LOS: if (cm && (s[i] || l)) begin nst = M_CD; m_acq[k][i] = 0; end
            M_CD: begin
              if (!dt) nst = M_LOS;
              else if (m_acq[k][i] == P_ACQ[k] - 1) begin
                nst = M_SA; m_bad[k][i] = 0; m_good[k][i] = 0;
              end else begin
                nst = M_AS; m_acq[k][i]++;
              end
            end
            M_AS: begin
              if (cm && !m_rxe[k][i]) nst = M_CD;
              else if (bd) nst = M_LOS;
            end
            default: begin
              if (bd) begin
                m_good[k][i] = 0;
                if (m_bad[k][i] == P_BAD[k] - 1) begin
                  nst = M_LOS;
                  if (m_loss[k][i] < 255) m_loss[k][i]++;
                end else m_bad[k][i]++;
              end else if (m_bad[k][i] > 0) begin
                m_good[k][i]++;
                if (m_good[k][i] == P_GOOD[k]) begin m_bad[k][i]--; m_good[k][i] = 0; end
              end
            end
          endcase
          m_rxe[k][i] = (nst == M_CD) ? 1'b1 : !m_rxe[k][i];
          m_st[k][i] = nst;
        end
      end
    end
  endtask

  typedef struct packed {
    logic [L-1:0]   st_a, rx_a, st_b, rx_b;
    logic [L*W-1:0] sudi_a, sudi_b;
    logic           all_a, all_b;
    logic [L*8-1:0] loss_a, loss_b;
  } exp_t;

  exp_t expq[$];

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < L; i++) begin
      e.st_a[i] = (m_st[0][i] == M_SA);
      e.st_b[i] = (m_st[1][i] == M_SA);
      e.rx_a[i] = m_rxe[0][i];
      e.rx_b[i] = m_rxe[1][i];
`ifdef SYNC_LOSS_CNT_EN
      e.loss_a[i*8 +: 8] = 8'(m_loss[0][i]);
      e.loss_b[i*8 +: 8] = 8'(m_loss[1][i]);
`else
      e.loss_a[i*8 +: 8] = 8'h00;
      e.loss_b[i*8 +: 8] = 8'h00;
`endif
    end
    e.sudi_a = m_sudi[0];
    e.sudi_b = m_sudi[1];
    e.all_a = m_all[0];
    e.all_b = m_all[1];
    return e;
  endfunction

  task automatic step(input logic [L*W-1:0] c, input logic [L-1:0] s, input bit l, input bit r);
    @(negedge clk);
    cg = c; sd = s; lb = l; rst_n = r;
    model_step(0, c, s, l, r);
    model_step(1, c, s, l, r);
    expq.push_back(snap());
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  // Comma on even-expected slots, D16.2 otherwise, chosen from the model's phase of instance A.
  function automatic logic [L*W-1:0] good_vec();
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++)
      v[i*W +: W] = m_rxe[0][i] ? D16P2 : ($urandom_range(0, 1) ? K28P5_RDN : K28P5_RDP);
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("a_status", st_a, e.st_a);
        chk("a_rx_even", rx_a, e.rx_a);
        chk("a_sudi", sudi_a, e.sudi_a);
        chk("a_all_sync", all_a, e.all_a);
        chk("b_status", st_b, e.st_b);
        chk("b_rx_even", rx_b, e.rx_b);
        chk("b_sudi", sudi_b, e.sudi_b);
        chk("b_all_sync", all_b, e.all_b);
`ifdef SYNC_LOSS_CNT_EN
        chk("a_loss_cnt", loss_a, e.loss_a);
        chk("b_loss_cnt", loss_b, e.loss_b);
`endif
      end
    end
  end

  initial begin : stim
    logic [L*W-1:0] v;
    logic [L-1:0] s;
    bit l, r;

    repeat (3) step('0, '1, 0, 0);
    after_edge();
    chk("rst_status", st_a, 4'h0);
    chk("rst_rx_even", rx_a, 4'h0);
    chk("rst_sudi", sudi_a, '0);
    chk("rst_all_sync", all_a, 1'b0);

    // Acquisition: B locks after one pair, A after three.
    step(good_vec(), '1, 0, 1);
    step(good_vec(), '1, 0, 1);
    after_edge();
    chk("b_fast_acq", st_b, 4'hF);
    chk("a_not_yet", st_a, 4'h0);
    repeat (3) step(good_vec(), '1, 0, 1);
    after_edge();
    chk("a_pre_acq", st_a, 4'h0);
    step(good_vec(), '1, 0, 1);
    after_edge();
    chk("a_acq_6th", st_a, 4'hF);
    v = good_vec();
    step(v, '1, 0, 1);
    after_edge();
    chk("a_all_sync_lag", all_a, 1'b1);
    chk("a_sudi_delay", sudi_a, v);

    // Single error recovers; hysteresis on B.
    v = good_vec(); v[9:0] = 10'h000; step(v, '1, 0, 1);
    repeat (4) step(good_vec(), '1, 0, 1);
    after_edge();
    chk("one_bad_keep", st_a, 4'hF);
    v = good_vec(); v[9:0] = 10'h000; step(v, '1, 0, 1);
    repeat (2) step(good_vec(), '1, 0, 1);
    v = good_vec(); v[9:0] = 10'h000; step(v, '1, 0, 1);
    after_edge();
    chk("b_bad_good_bad_keep", st_b[0], 1'b1);
    repeat (8) step(good_vec(), '1, 0, 1);
    for (int n = 1; n <= 4; n++) begin
      v = good_vec(); v[9:0] = 10'h000; step(v, '1, 0, 1);
      after_edge();
      if (n == 2) chk("b_loss_2nd", st_b[0], 1'b0);
      if (n == 3) chk("a_keep_3rd", st_a[0], 1'b1);
    end
    chk("a_loss_4th", st_a[0], 1'b0);
`ifdef SYNC_LOSS_CNT_EN
    chk("a_loss_cnt_1", loss_a[7:0], 8'd1);
`endif
    repeat (12) step(good_vec(), '1, 0, 1);
    after_edge();
    chk("a_reacq", st_a, 4'hF);

    // Commas in the odd slot on lane 1.
    for (int n = 0; n < 4; n++) begin
      v = good_vec();
      v[19:10] = m_rxe[0][1] ? K28P5_RDN : 10'h000;
      step(v, '1, 0, 1);
    end
    after_edge();
    chk("odd_comma_loss", st_a[1], 1'b0);
    repeat (12) step(good_vec(), '1, 0, 1);
    after_edge();
    chk("even_comma_ok", st_a, 4'hF);

    // Signal change on lane 2, then the same with loopback masking it.
    step(good_vec(), 4'b1011, 0, 1);
    after_edge();
    chk("sd_lane2_drop", st_a, 4'b1011);
    step(good_vec(), 4'b1011, 0, 1);
    after_edge();
    chk("sd_all_sync_drop", all_a, 1'b0);
    repeat (14) step(good_vec(), '1, 0, 1);
    after_edge();
    chk("sd_reacq", st_a, 4'hF);
    step(good_vec(), 4'b1011, 1, 1);
    after_edge();
    chk("lb_masks_sd", st_a, 4'hF);
    step(good_vec(), '1, 1, 1);
    step(good_vec(), '1, 0, 1);

    // Reset in the middle of acquisition.
    step(good_vec(), '1, 0, 0);
    repeat (2) step(good_vec(), '1, 0, 1);
    step(good_vec(), '1, 0, 0);
    after_edge();
    chk("midacq_rst_status", st_a, 4'h0);
    chk("midacq_rst_sudi", sudi_a, '0);
    repeat (5) step(good_vec(), '1, 0, 1);
    after_edge();
    chk("reacq_5th", st_a, 4'h0);
    step(good_vec(), '1, 0, 1);
    after_edge();
    chk("reacq_6th", st_a, 4'hF);

    // Randomized traffic with sparse disturbances.
    s = '1; l = 0;
    for (int c = 0; c < 3000; c++) begin
      v = good_vec();
      for (int i = 0; i < L; i++) begin
        int p;
        p = $urandom_range(0, 99);
        if (p >= 80 && p < 88) v[i*W +: W] = 10'($urandom);
        else if (p >= 88 && p < 94) v[i*W +: W] = 10'h000;
        else if (p >= 94) v[i*W +: W] = K28P5_RDN;
        if ($urandom_range(0, 99) == 0) s[i] = ~s[i];
      end
      if ($urandom_range(0, 49) == 0) l = ~l;
      r = ($urandom_range(0, 299) != 0);
      step(v, s, l, r);
    end

    repeat (4) @(posedge clk);
    #3;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
